// File: rtl/txrx_interface.sv
// txrx_interface: memory-mapped TX/RX FIFO bridge between the datapath load/store port and the link serializer.
// Latency: a TX_DATA write is on tx_data/tx_valid the next cycle; an accepted RX word is readable the next cycle; register reads are combinational.
// Backpressure: tx_ready stalls the TX head; rx_ready = RX not full; TX writes while full are dropped and flagged in tx_drop.
//
// Ports: clk/rst (async active-low); address_rw/data_in/memory_write_enable/memory_read_enable form the CPU
// register port; peripheral_select/peripheral_data_out feed the datapath read mux; tx_* and rx_* are the
// valid/ready link channels; rx_interrupt is a registered "RX has data" request gated by CTRL[1].
// Optional build: define TXRX_LOOPBACK_EN to implement CTRL[0] internal loopback (TX head -> RX FIFO).

// Generic synchronous FIFO, first-word fall-through head. Push when full and pop when empty are ignored.
// Latency: pushed word visible at head_dat the cycle after the push if the FIFO was empty.
// Backpressure: none internally; the caller gates push/pop using count.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok  = push && (count != FULL_CNT);
    assign pop_ok   = pop && (count != '0);
    assign head_dat = mem[rd_ptr];

    // Pointer width is exactly log2(DEPTH), so the increments wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset: contents are meaningless once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end
endmodule

module txrx_interface #(
    parameter logic [15:0] BASE_ADDRESS = 16'hFFF0,
    parameter int          DATA_WIDTH   = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           address_rw,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  memory_write_enable,
    input  logic                  memory_read_enable,
    output logic                  peripheral_select,
    output logic [DATA_WIDTH-1:0] peripheral_data_out,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  rx_interrupt
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] REG_TX_DATA = 2'd0;
    localparam logic [1:0] REG_RX_DATA = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    // Address decode: unsigned subtraction wraps addresses below the base to large offsets.
    logic [15:0] offset;
    logic [1:0]  reg_idx;
    assign offset            = address_rw - BASE_ADDRESS;
    assign peripheral_select = (offset < 16'd4);
    assign reg_idx           = offset[1:0];

    logic wr_tx, rd_rx, rd_status, wr_ctrl;
    assign wr_tx     = memory_write_enable && peripheral_select && (reg_idx == REG_TX_DATA);
    assign rd_rx     = memory_read_enable  && peripheral_select && (reg_idx == REG_RX_DATA);
    assign rd_status = memory_read_enable  && peripheral_select && (reg_idx == REG_STATUS);
    assign wr_ctrl   = memory_write_enable && peripheral_select && (reg_idx == REG_CTRL);

    logic [CNT_W-1:0]      tx_count, rx_count;
    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic [DATA_WIDTH-1:0] rx_head;
    logic                  tx_push, tx_pop, rx_push, rx_pop;
    logic [DATA_WIDTH-1:0] rx_push_dat;
    logic                  tx_drop, rx_underrun, irq_enable, link_en;
    logic                  loopback, lb_move;

    assign tx_full  = (tx_count == FULL_CNT);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == FULL_CNT);
    assign rx_empty = (rx_count == '0);

    // Held low through reset so the link sees no ready until the first clock after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) link_en <= 1'b0;
        else      link_en <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         irq_enable <= 1'b0;
        else if (wr_ctrl) irq_enable <= data_in[1];
    end

`ifdef TXRX_LOOPBACK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         loopback <= 1'b0;
        else if (wr_ctrl) loopback <= data_in[0];
    end
    assign lb_move = loopback && !tx_empty && !rx_full;
`else
    assign loopback = 1'b0;
    assign lb_move  = 1'b0;
`endif

    assign tx_valid = !tx_empty && !loopback;
    assign rx_ready = link_en && !rx_full && !loopback;

    // A write while full is dropped based on the registered full flag, even if the link pops this edge.
    assign tx_push     = wr_tx && !tx_full;
    assign tx_pop      = (tx_valid && tx_ready) || lb_move;
    assign rx_push     = (rx_valid && rx_ready) || lb_move;
    assign rx_push_dat = lb_move ? tx_data : rx_data;
    assign rx_pop      = rd_rx && !rx_empty;

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tx_push),
        .push_dat (data_in),
        .pop      (tx_pop),
        .head_dat (tx_data),
        .count    (tx_count)
    );

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rx_push),
        .push_dat (rx_push_dat),
        .pop      (rx_pop),
        .head_dat (rx_head),
        .count    (rx_count)
    );

    // Sticky error flags: a STATUS read clears them, but a set on the same edge wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_drop     <= 1'b0;
            rx_underrun <= 1'b0;
        end else begin
            tx_drop     <= (wr_tx && tx_full)  || (tx_drop && !rd_status);
            rx_underrun <= (rd_rx && rx_empty) || (rx_underrun && !rd_status);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_interrupt <= 1'b0;
        else      rx_interrupt <= irq_enable && !rx_empty;
    end

    logic [15:0] status_word;
    logic [15:0] ctrl_word;
    assign status_word = {8'(rx_count), 2'b00, rx_underrun, tx_drop,
                          rx_empty, rx_full, tx_empty, tx_full};
    assign ctrl_word   = {14'b0, irq_enable, loopback};

    always_comb begin
        peripheral_data_out = '0;
        if (peripheral_select) begin
            case (reg_idx)
                REG_RX_DATA: if (!rx_empty) peripheral_data_out = rx_head;
                REG_STATUS:  peripheral_data_out = DATA_WIDTH'(status_word);
                REG_CTRL:    peripheral_data_out = DATA_WIDTH'(ctrl_word);
                default:     peripheral_data_out = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_txrx_interface.sv
module tb_txrx_interface;
    localparam logic [15:0] A_TX = 16'hFFF0;
    localparam logic [15:0] A_RX = 16'hFFF1;
    localparam logic [15:0] A_ST = 16'hFFF2;
    localparam logic [15:0] A_CT = 16'hFFF3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] address_rw = '0;
    logic [15:0] data_in = '0;
    logic        memory_write_enable = 1'b0;
    logic        memory_read_enable = 1'b0;
    logic        peripheral_select;
    logic [15:0] peripheral_data_out;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [15:0] rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        rx_interrupt;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    txrx_interface dut (
        .clk                 (clk),
        .rst                 (rst),
        .address_rw          (address_rw),
        .data_in             (data_in),
        .memory_write_enable (memory_write_enable),
        .memory_read_enable  (memory_read_enable),
        .peripheral_select   (peripheral_select),
        .peripheral_data_out (peripheral_data_out),
        .tx_data             (tx_data),
        .tx_valid            (tx_valid),
        .tx_ready            (tx_ready),
        .rx_data             (rx_data),
        .rx_valid            (rx_valid),
        .rx_ready            (rx_ready),
        .rx_interrupt        (rx_interrupt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    // Bus helpers: drive 1 time unit after a rising edge, sample on the falling edge.
    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        address_rw = a; data_in = d; memory_write_enable = 1'b1;
        @(posedge clk); #1;
        memory_write_enable = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [15:0] d, output logic sel);
        @(posedge clk); #1;
        address_rw = a; memory_read_enable = 1'b1;
        @(negedge clk);
        d = peripheral_data_out; sel = peripheral_select;
        @(posedge clk); #1;
        memory_read_enable = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] d; logic s;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b0 || tx_valid !== 1'b0 || rx_interrupt !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: rx_ready=%b tx_valid=%b irq=%b, required 0 0 0", rx_ready, tx_valid, rx_interrupt);
        end
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rx_ready=%b tx_valid=%b, required 1 0", rx_ready, tx_valid);
        end
        cpu_read(A_ST, d, s);
        checks++;
        if (d !== 16'h000A) begin errors++; $display("FAIL reset_status: got %h required 000a", d); end
        cpu_read(A_CT, d, s);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL reset_ctrl: got %h required 0000", d); end
    endtask

    task automatic test_decode;
        logic [15:0] d; logic s;
        cpu_read(16'hFFEF, d, s);
        checks++;
        if (s !== 1'b0 || d !== 16'h0000) begin errors++; $display("FAIL decode_below: sel=%b data=%h required 0 0000", s, d); end
        cpu_read(16'hFFF4, d, s);
        checks++;
        if (s !== 1'b0 || d !== 16'h0000) begin errors++; $display("FAIL decode_above: sel=%b data=%h required 0 0000", s, d); end
        cpu_read(A_CT, d, s);
        checks++;
        if (s !== 1'b1) begin errors++; $display("FAIL decode_top: sel=%b required 1", s); end
        cpu_write(16'hFFEF, 16'h1111);
        cpu_write(16'hFFF4, 16'h2222);
        cpu_write(A_ST, 16'hFFFF);
        cpu_write(A_RX, 16'h3333);
        cpu_read(A_ST, d, s);
        checks++;
        if (d !== 16'h000A) begin errors++; $display("FAIL decode_ignored_writes: status %h required 000a", d); end
    endtask

    task automatic test_tx;
        logic [15:0] e;
        int n = 0, first_c = 0, last_c = 0;
        tx_ready = 1'b0;
        cpu_write(A_TX, 16'h1234); exp_q.push_back(16'h1234);
        cpu_write(A_TX, 16'hABCD); exp_q.push_back(16'hABCD);
        @(posedge clk); #1; tx_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL tx_extra: unexpected word %h", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin errors++; $display("FAIL tx_data: got %h required %h", tx_data, e); end
                end
                if (n == 0) first_c = c;
                last_c = c;
                n++;
            end
        end
        checks++;
        if (n != 2 || (last_c - first_c) != 1) begin
            errors++; $display("FAIL tx_b2b: transfers=%0d span=%0d required 2 1", n, last_c - first_c);
        end
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_idle: tx_valid=%b required 0", tx_valid); end
        @(posedge clk); #1; tx_ready = 1'b0;
    endtask

    task automatic test_tx_full;
        logic [15:0] d, e; logic s;
        int n = 0;
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cpu_write(A_TX, 16'hC000 + 16'(i));
            if (i < 8) exp_q.push_back(16'hC000 + 16'(i));
        end
        cpu_read(A_ST, d, s);
        checks++;
        if (d !== 16'h0019) begin errors++; $display("FAIL tx_full_status: got %h required 0019", d); end
        cpu_read(A_ST, d, s);
        checks++;
        if (d !== 16'h0009) begin errors++; $display("FAIL tx_drop_clear: got %h required 0009", d); end
        // Write while full on the same edge as a link pop: still dropped.
        @(posedge clk); #1;
        address_rw = A_TX; data_in = 16'hDEAD; memory_write_enable = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        checks++;
        e = exp_q.pop_front();
        if (!(tx_valid && tx_data === e)) begin errors++; $display("FAIL tx_pop_while_full: valid=%b data=%h required 1 %h", tx_valid, tx_data, e); end
        @(posedge clk); #1;
        memory_write_enable = 1'b0; tx_ready = 1'b0;
        cpu_read(A_ST, d, s);
        checks++;
        if (d !== 16'h0018) begin errors++; $display("FAIL tx_drop_with_pop: status %h required 0018", d); end
        @(posedge clk); #1; tx_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL tx_full_extra: unexpected word %h", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin errors++; $display("FAIL tx_full_data: got %h required %h", tx_data, e); end
                end
                n++;
            end
        end
        checks++;
        if (n != 7 || exp_q.size() != 0) begin errors++; $display("FAIL tx_full_drain: transfers=%0d left=%0d required 7 0", n, exp_q.size()); end
        @(posedge clk); #1; tx_ready = 1'b0;
    endtask

    task automatic test_rx;
        logic [15:0] d, e; logic s;
        int t;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            rx_data = 16'(i); rx_valid = 1'b1;
            @(negedge clk);
            t = 0;
            while (!rx_ready && t < 20) begin @(negedge clk); t++; end
            checks++;
            if (!rx_ready) begin errors++; $display("FAIL rx_ready_timeout: word %0d rx_ready=%b required 1", i, rx_ready); end
            else exp_q.push_back(16'(i));
        end
        @(posedge clk); #1;
        rx_data = 16'h00FF;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_full_ready: rx_ready=%b required 0", rx_ready); end
        repeat (3) @(posedge clk);
        #1; rx_valid = 1'b0;
        cpu_read(A_ST, d, s);
        checks++;
        if (d !== 16'h0806) begin errors++; $display("FAIL rx_full_status: got %h required 0806", d); end
        for (int i = 0; i < 8; i++) begin
            cpu_read(A_RX, d, s);
            checks++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hXXXX;
            if (d !== e) begin errors++; $display("FAIL rx_data: got %h required %h", d, e); end
        end
        cpu_read(A_RX, d, s);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL rx_underrun_data: got %h required 0000", d); end
        cpu_read(A_ST, d, s);
        checks++;
        if (d !== 16'h002A) begin errors++; $display("FAIL rx_underrun_status: got %h required 002a", d); end
        cpu_read(A_ST, d, s);
        checks++;
        if (d !== 16'h000A) begin errors++; $display("FAIL rx_underrun_clear: got %h required 000a", d); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] d, e; logic s;
        @(posedge clk); #1; rx_valid = 1'b1; rx_data = 16'h00A1;
        @(posedge clk); #1; rx_data = 16'h00A2;
        @(posedge clk); #1; rx_valid = 1'b0;
        exp_q.push_back(16'h00A1); exp_q.push_back(16'h00A2);
        // Pop and push on the same edge.
        @(posedge clk); #1;
        address_rw = A_RX; memory_read_enable = 1'b1; rx_valid = 1'b1; rx_data = 16'h00A3;
        @(negedge clk);
        d = peripheral_data_out;
        checks++;
        e = exp_q.pop_front();
        if (d !== e || rx_ready !== 1'b1) begin errors++; $display("FAIL b2b_pop: data=%h rx_ready=%b required %h 1", d, rx_ready, e); end
        @(posedge clk); #1;
        memory_read_enable = 1'b0; rx_valid = 1'b0;
        exp_q.push_back(16'h00A3);
        cpu_read(A_ST, d, s);
        checks++;
        if (d !== 16'h0202) begin errors++; $display("FAIL b2b_count: status %h required 0202", d); end
        for (int i = 0; i < 2; i++) begin
            cpu_read(A_RX, d, s);
            checks++;
            e = exp_q.pop_front();
            if (d !== e) begin errors++; $display("FAIL b2b_data: got %h required %h", d, e); end
        end
    endtask

    task automatic test_irq;
        logic [15:0] d; logic s;
        cpu_write(A_CT, 16'hFFFE);
        cpu_read(A_CT, d, s);
        checks++;
        if (d !== 16'h0002) begin errors++; $display("FAIL ctrl_mask: got %h required 0002", d); end
`ifndef TXRX_LOOPBACK_EN
        cpu_write(A_CT, 16'h0003);
        cpu_read(A_CT, d, s);
        checks++;
        if (d !== 16'h0002) begin errors++; $display("FAIL ctrl_no_loopback: got %h required 0002", d); end
`endif
        @(posedge clk); #1; rx_valid = 1'b1; rx_data = 16'h0077;
        @(posedge clk); #1; rx_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_interrupt !== 1'b0) begin errors++; $display("FAIL irq_early: irq=%b required 0", rx_interrupt); end
        @(negedge clk);
        checks++;
        if (rx_interrupt !== 1'b1) begin errors++; $display("FAIL irq_set: irq=%b required 1", rx_interrupt); end
        cpu_read(A_RX, d, s);
        checks++;
        if (d !== 16'h0077) begin errors++; $display("FAIL irq_data: got %h required 0077", d); end
        @(posedge clk); @(negedge clk);
        checks++;
        if (rx_interrupt !== 1'b0) begin errors++; $display("FAIL irq_clear: irq=%b required 0", rx_interrupt); end
        cpu_write(A_CT, 16'h0000);
    endtask

`ifdef TXRX_LOOPBACK_EN
    task automatic test_loopback;
        logic [15:0] d; logic s;
        int bad = 0;
        cpu_write(A_CT, 16'h0001);
        cpu_read(A_CT, d, s);
        checks++;
        if (d !== 16'h0001) begin errors++; $display("FAIL lb_ctrl: got %h required 0001", d); end
        tx_ready = 1'b1;
        cpu_write(A_TX, 16'h5A5A);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (tx_valid !== 1'b0 || rx_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL lb_link_quiet: %0d cycles with link active, required 0", bad); end
        cpu_read(A_RX, d, s);
        checks++;
        if (d !== 16'h5A5A) begin errors++; $display("FAIL lb_data: got %h required 5a5a", d); end
        cpu_write(A_CT, 16'h0000);
        tx_ready = 1'b0;
    endtask
`endif

    task automatic test_reset_mid;
        logic [15:0] d; logic s;
        tx_ready = 1'b0;
        cpu_write(A_TX, 16'h0101);
        cpu_write(A_TX, 16'h0202);
        cpu_write(A_CT, 16'h0002);
        @(posedge clk); #1; rx_valid = 1'b1; rx_data = 16'h0009;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b0 || tx_valid !== 1'b0 || rx_interrupt !== 1'b0) begin
            errors++; $display("FAIL midreset_hold: rx_ready=%b tx_valid=%b irq=%b required 0 0 0", rx_ready, tx_valid, rx_interrupt);
        end
        @(posedge clk); #1; rx_valid = 1'b0; rst = 1'b1;
        cpu_read(A_ST, d, s);
        checks++;
        if (d !== 16'h000A) begin errors++; $display("FAIL midreset_status: got %h required 000a", d); end
        cpu_read(A_CT, d, s);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL midreset_ctrl: got %h required 0000", d); end
        checks++;
        if (tx_valid !== 1'b0 || rx_interrupt !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: tx_valid=%b irq=%b required 0 0", tx_valid, rx_interrupt);
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_tx();
        test_tx_full();
        test_rx();
        test_back_to_back();
        test_irq();
`ifdef TXRX_LOOPBACK_EN
        test_loopback();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
